// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared encodings and constants for the iterative RV32M unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

    localparam int unsigned c_iter_count = 32;
    localparam int unsigned c_cnt_w      = $clog2(c_iter_count);

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational shift-add (multiply) or restoring (divide) step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step
    import muldiv_pkg::*;
(
    input  step_mode_t  mode,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next,
    output logic        q_bit
);

    logic [32:0] w_sum;
    logic [32:0] w_pr;
    logic [32:0] w_diff;

    // Multiply: acc = {partial hi, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting out / quotient in}.
    always_comb begin
        w_sum    = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
        w_pr     = {acc[63:32], acc[31]};
        w_diff   = w_pr - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = {w_sum, acc[31:1]};
        if (mode == STEP_DIV) begin
            // Partial remainder stays below 2*divisor, so bit 32 is a clean borrow.
            q_bit    = ~w_diff[32];
            acc_next = {(q_bit ? w_diff[31:0] : w_pr[31:0]), acc[30:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_iter_count - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_op;
    logic                 r_neg;
    logic                 r_rem_neg;
    logic [63:0]          r_acc;
    logic [31:0]          r_operand;
    logic [c_cnt_w-1:0]   r_counter;
    logic [31:0]          r_result;

    logic        w_accept;
    logic        w_last;
    logic        w_sa;
    logic        w_sb;
    logic        w_signed_div;
    logic        w_fast;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_fast_result;
    logic [63:0] w_acc_next;
    logic        w_qbit;
    logic [63:0] w_acc_iter;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_final_result;

    assign w_accept = start && (r_state != S_CALC);
    assign w_last   = (r_counter == c_last);

    // Operand decode on the accept edge
    always_comb begin
        w_sa         = a[31] && (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                                 op == OP_DIV || op == OP_REM);
        w_sb         = b[31] && (op == OP_MUL || op == OP_MULH ||
                                 op == OP_DIV || op == OP_REM);
        w_a_mag      = w_sa ? (32'd0 - a) : a;
        w_b_mag      = w_sb ? (32'd0 - b) : b;
        w_signed_div = (op == OP_DIV) || (op == OP_REM);
        w_fast       = 1'b0;
        w_fast_result = 32'd0;
        if (op[2] && (b == 32'd0)) begin
            w_fast        = 1'b1;
            w_fast_result = op[1] ? a : 32'hFFFF_FFFF;
        end else if (w_signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            w_fast        = 1'b1;
            w_fast_result = op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    muldiv_step u_step (
        .mode     (step_mode_t'(r_op[2])),
        .acc      (r_acc),
        .operand  (r_operand),
        .acc_next (w_acc_next),
        .q_bit    (w_qbit)
    );

    assign w_acc_iter = w_acc_next | {63'd0, w_qbit};

    // Sign fix-up and result selection on the final iteration
    always_comb begin
        w_prod = r_neg ? (64'd0 - w_acc_iter) : w_acc_iter;
        w_quot = r_neg ? (32'd0 - w_acc_iter[31:0]) : w_acc_iter[31:0];
        w_rem  = r_rem_neg ? (32'd0 - w_acc_iter[63:32]) : w_acc_iter[63:32];
        case (r_op)
            OP_MUL:                       w_final_result = w_prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final_result = w_prod[63:32];
            OP_DIV, OP_DIVU:              w_final_result = w_quot;
            default:                      w_final_result = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = w_fast ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (start) w_state_next = w_fast ? S_DONE : S_CALC;
                else       w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_acc     <= 64'd0;
            r_operand <= 32'd0;
            r_counter <= '0;
            r_result  <= 32'd0;
        end else if (w_accept) begin
            r_op      <= op;
            r_neg     <= w_sa ^ w_sb;
            r_rem_neg <= w_sa;
            r_acc     <= {32'd0, w_a_mag};
            r_operand <= w_b_mag;
            r_counter <= '0;
            if (w_fast) r_result <= w_fast_result;
        end else if (r_state == S_CALC) begin
            r_acc     <= w_acc_iter;
            r_counter <= r_counter + c_cnt_w'(1);
            if (w_last) r_result <= w_final_result;
        end
    end

    assign busy   = (r_state == S_CALC);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx, sy, q;
        logic [63:0] p;
        logic        ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sx * sy;                   return p[31:0];  end
            3'd1: begin p = sx * sy;                   return p[63:32]; end
            3'd2: begin p = sx * longint'({32'd0, y}); return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y};   return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                q = sx / sy; return q[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf)    return 32'd0;
                q = sx % sy; return q[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && ((y == 0) ||
               (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive a request now; return one sample point (#1) after its accept edge
    task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = f; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    // Follows an accepted op from lat cycles past its accept edge through done
    task automatic wait_check(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                              input int start_lat);
        int lat;
        bit fast;
        fast = is_fast(f, x, y);
        lat  = start_lat;
        while (!done && lat < 40) begin
            check("busy_calc", busy, !fast);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, fast ? 1 : 33);
        check("busy_at_done", busy, 0);
        check("result", result, ref_result(f, x, y));
    endtask

    task automatic check_after(input logic [31:0] held);
        @(posedge clk); #1;
        check("done_pulse_len", done, 0);
        check("busy_after", busy, 0);
        check("result_held", result, held);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        launch(f, x, y);
        wait_check(f, x, y, 1);
        check_after(ref_result(f, x, y));
    endtask

    initial begin
        int npulse;
        logic [2:0]  rf;
        logic [31:0] ra, rb, prev;
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);

        // Start coincident with reset is dropped
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_done", done, 0);
        @(posedge clk); #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd7, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Start pulsed mid-CALC with other operands is ignored
        launch(3'd0, 32'd7, 32'hFFFF_FFFD);
        repeat (4) @(posedge clk);
        #1;
        launch(3'd5, 32'd100, 32'd7);
        wait_check(3'd0, 32'd7, 32'hFFFF_FFFD, 6);

        // Start in the DONE cycle: next op timed from that edge
        launch(3'd5, 32'd100, 32'd7);
        wait_check(3'd5, 32'd100, 32'd7, 1);
        check_after(32'd14);

        // Reset mid-DIV: outputs clear and no done follows
        launch(3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        npulse = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        check("midrst_no_done", npulse, 0);
        run_op(3'd0, 32'd3, 32'd4);

        // Randomized ops, sometimes chained back-to-back from the DONE cycle
        prev = 32'd12;
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end
            launch(rf, ra, rb);
            wait_check(rf, ra, rb, 1);
            prev = ref_result(rf, ra, rb);
            if ($urandom_range(0, 1) == 0) check_after(prev);
        end
        check_after(prev);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
